// File: rtl/prog_loader_if.sv
// Bus bundle between the lab top level (buttons, switches, datapath fetch) and prog_loader.
// The master side drives buttons, switches and the fetch address; the slave side is the loader.
`timescale 1ns/1ps
interface prog_loader_if #(
    parameter int AW = 5,
    parameter int DW = 8
);
    logic          btn_wr;
    logic          btn_next;
    logic          btn_run;
    logic [DW-1:0] data_in;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] edit_addr;
    logic [DW-1:0] edit_data;
    logic          wr_strobe;
    logic          run_mode;
    logic          busy;

    modport master (
        output btn_wr, btn_next, btn_run, data_in, rd_addr,
        input  rd_data, edit_addr, edit_data, wr_strobe, run_mode, busy
    );

    modport slave (
        input  btn_wr, btn_next, btn_run, data_in, rd_addr,
        output rd_data, edit_addr, edit_data, wr_strobe, run_mode, busy
    );
endinterface

// File: rtl/prog_loader.sv
// Program-ROM writer: clears a 2**AW x DW memory after reset, lets the user fill it from switches,
// and serves it to the datapath in RUN. Define PROG_LOADER_AUTOINC_EN to auto-advance the pointer on writes.
`timescale 1ns/1ps
module prog_loader #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    prog_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_clr_cnt;
    logic [AW-1:0] w_clr_cnt_nxt;
    logic [AW-1:0] r_edit_addr;
    logic [AW-1:0] w_edit_addr_nxt;
    logic          r_prev_wr;
    logic          r_prev_next;
    logic          r_prev_run;

    logic          w_edge_wr;
    logic          w_edge_next;
    logic          w_edge_run;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_waddr;
    logic [DW-1:0] w_mem_wdata;
    logic          w_run;

    logic [DW-1:0] r_mem [2**AW];

    assign w_edge_wr   = bus.btn_wr   & ~r_prev_wr;
    assign w_edge_next = bus.btn_next & ~r_prev_next;
    assign w_edge_run  = bus.btn_run  & ~r_prev_run;

    // NOTE: every output of this block gets a default before the case, so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_nxt     = r_state;
        w_clr_cnt_nxt   = r_clr_cnt;
        w_edit_addr_nxt = r_edit_addr;
        w_mem_we        = 1'b0;
        w_mem_waddr     = r_edit_addr;
        w_mem_wdata     = bus.data_in;

        case (r_state)
            S_CLEAR: begin
                w_mem_we      = 1'b1;
                w_mem_waddr   = r_clr_cnt;
                w_mem_wdata   = '0;
                w_clr_cnt_nxt = r_clr_cnt + AW'(1);
                if (r_clr_cnt == {AW{1'b1}}) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                // Only the highest-priority edge acts; the others are dropped this cycle.
                if (w_edge_wr) begin
                    w_state_nxt = S_WRITE;
                end else if (w_edge_next) begin
                    w_edit_addr_nxt = r_edit_addr + AW'(1);
                end else if (w_edge_run) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_WRITE: begin
                w_mem_we = 1'b1;
`ifdef PROG_LOADER_AUTOINC_EN
                w_edit_addr_nxt = r_edit_addr + AW'(1);
`else
                w_edit_addr_nxt = r_edit_addr;
`endif
                w_state_nxt = S_LOAD;
            end
            S_RUN: begin
                if (w_edge_run) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_CLEAR;
            r_clr_cnt   <= '0;
            r_edit_addr <= '0;
            r_prev_wr   <= 1'b0;
            r_prev_next <= 1'b0;
            r_prev_run  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_cnt   <= w_clr_cnt_nxt;
            r_edit_addr <= w_edit_addr_nxt;
            r_prev_wr   <= bus.btn_wr;
            r_prev_next <= bus.btn_next;
            r_prev_run  <= bus.btn_run;
        end
    end

    // NOTE: the memory array has no reset; S_CLEAR zeroes it, which keeps it mappable to plain RAM.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    assign w_run          = (r_state == S_RUN);
    assign bus.run_mode   = w_run;
    assign bus.busy       = (r_state == S_CLEAR);
    assign bus.wr_strobe  = (r_state == S_WRITE);
    assign bus.edit_addr  = r_edit_addr;
    assign bus.edit_data  = r_mem[r_edit_addr];
    // Outside RUN the datapath fetches a NOP.
    assign bus.rd_data    = w_run ? r_mem[bus.rd_addr] : '0;

endmodule
